mem_stage: RTL
==============

Name: mem_stage

Overview:
Pipeline MEM stage. It consumes the EXE/MEM register contents produced by the execute stage, and drives the data-memory request/grant/response handshake with byte-lane strobes and load extension. It stalls upstream stages while an access is outstanding, and registers results into the MEM/WB register. It also supplies RD_W, RegWriteW and WriteDataW back to the execute-stage forwarding unit.

Parameters:
DMEM_ADDR_W, 32, data-memory address width. dmem_addr is ALU_ResultM[DMEM_ADDR_W-1:0] with bits [2:0] forced to 0.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
ValidM  in  1  EXE/MEM entry holds a real instruction
RegWriteM  in  1  instruction writes rd
MemToRegM  in  1  writeback selects load data
MemReadM  in  1  load
MemWriteM  in  1  store
MemTypeM  in  2  00 byte, 01 half, 10 word, 11 double
LoadUnsignedM  in  1  zero-extend load (lbu/lhu/lwu)
RD_M  in  5  destination register
ALU_ResultM  in  64  effective address or ALU result
WriteDataM  in  64  store data, right-aligned
dmem_req  out  1  access request
dmem_we  out  1  1 = store
dmem_addr  out  DMEM_ADDR_W  doubleword-aligned address
dmem_wdata  out  64  store data shifted to its lane
dmem_wstrb  out  8  byte-enable strobes
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  load data valid
dmem_rdata  in  64  load doubleword
StallM  out  1  hold IF/ID/EXE and the EXE/MEM register
ValidW  out  1  MEM/WB entry valid
RegWriteW  out  1  registered; equals RegWriteM and ValidW
RD_W  out  5  registered destination
WriteDataW  out  64  registered writeback value (load data or ALU result)

Behaviour:
- States: IDLE, REQ, WAIT.
- Reset: async on reset_n low. State goes to IDLE; all outputs are 0; dmem_req is 0. Any in-flight access is abandoned, and a late rvalid after reset is ignored.
- mem_op = ValidM & (MemReadM | MemWriteM).
- IDLE, non-mem op or bubble: single-cycle pass-through. On the next edge: ValidW=ValidM, RD_W=RD_M, RegWriteW=RegWriteM&ValidM, WriteDataW=ALU_ResultM. StallM=0.
- IDLE with mem_op: StallM=1 combinationally, dmem_req=1 in the same cycle, and the FSM enters REQ. If gnt is already high that cycle:
  - store: complete immediately.
  - load: go to WAIT.
- REQ: dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_wstrb are held stable until dmem_gnt. On gnt, a store goes to IDLE and a load goes to WAIT. StallM=1.
- WAIT: StallM=1, dmem_req=0. When rvalid is seen, the load result goes into WriteDataW and the FSM goes to IDLE.
- Stall-release cycle: StallM=0 in the cycle gnt (store) or rvalid (load) is seen, so the EXE/MEM register advances on that edge. The MEM/WB register captures the completed instruction, with ValidW=1, on that same edge.
- While stalled (StallM=1 and completion not seen): ValidW is 0 on each edge (bubble), RegWriteW=0.
- Lanes: lane = ALU_ResultM[2:0].
  - wstrb: byte 0x01<<lane; half 0x03<<lane; word 0x0F<<lane; double 0xFF.
  - wdata = WriteDataM << (8*lane).
  - Load: rdata >> (8*lane), truncated to size. Sign-extended unless LoadUnsignedM; a double is never extended.
- Misaligned access (lane not a multiple of size) without the optional feature: strobes wrap-truncate to 8 bits, bytes beyond lane 7 are dropped, and no error is flagged.
- Simultaneous gnt and rvalid in REQ: rvalid is ignored. The responder must not assert rvalid before the cycle after gnt.
- Latency: non-mem 1 cycle. A store with immediate gnt takes 1 cycle. A load takes a minimum of 2 cycles (gnt in cycle 0, rvalid in cycle 1).

Optional Feature:
MEM_MISALIGN_TRAP_EN.
- Defined: adds output MisalignW (1 bit, reset 0).
  - A misaligned mem_op raises no dmem_req and completes in 1 cycle.
  - ValidW=1, RegWriteW=0, MisalignW=1; WriteDataW is the faulting address.
- Undefined: the port is absent and the wrap-truncate behaviour above applies.

Test Plan:
1. Reset release, non-mem op RD_M=5, ALU_ResultM=0x2A, RegWriteM=1 -> next edge ValidW=1, RD_W=5, WriteDataW=0x2A; StallM never 1.
2. Store byte to address 0x1003, WriteDataM=0xAB, gnt held low 2 cycles -> dmem_req high 3 cycles with addr 0x1000, wstrb=0x08, wdata=0xAB000000. StallM=1 for 2 cycles. ValidW=1 after gnt.
3. lb at 0x2005 with rdata=0x0000_80FF_0000_0000 and rvalid 1 cycle after gnt -> WriteDataW=0xFFFF_FFFF_FFFF_FF80. With LoadUnsignedM=1 -> 0x80.
4. ld at 0x3000 with rdata=0x1122334455667788, rvalid delayed 4 cycles -> 4 bubbles (ValidW=0), then WriteDataW=0x1122334455667788 with RegWriteW=1.
5. reset_n asserted during WAIT, with rvalid arriving after release -> state IDLE, all outputs 0, late rvalid produces no ValidW.
6. With MEM_MISALIGN_TRAP_EN: lw at 0x4002 -> no dmem_req; MisalignW=1, RegWriteW=0, WriteDataW=0x4002.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage.
// Takes the EXE/MEM register contents and runs the data-memory access. It
// places store bytes on their byte lanes and extends load data. It stalls the
// front of the pipeline while an access is outstanding. Results go into the
// MEM/WB register, which also feeds the execute-stage forwarding unit.
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   Defined:   misaligned accesses raise no request. They complete in one
//              cycle with MisalignW=1, and WriteDataW holds the faulting address.
//   Undefined: misaligned accesses go to memory. Strobes wrap-truncate to
//              8 bits, and bytes beyond lane 7 are dropped.
//
// Data-memory handshake:
//   dmem_req is held high, with we/addr/wdata/wstrb stable, until the cycle in
//   which dmem_gnt is sampled high; that cycle transfers the request. For a
//   load, the responder returns exactly one dmem_rvalid pulse with dmem_rdata,
//   no earlier than the cycle after the grant. An rvalid that arrives while
//   the stage is not waiting for load data is ignored.
module mem_stage #(
  parameter int DMEM_ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ValidM,
  input  logic                   RegWriteM,
  input  logic                   MemToRegM,
  input  logic                   MemReadM,
  input  logic                   MemWriteM,
  input  logic [1:0]             MemTypeM,
  input  logic                   LoadUnsignedM,
  input  logic [4:0]             RD_M,
  input  logic [63:0]            ALU_ResultM,
  input  logic [63:0]            WriteDataM,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [DMEM_ADDR_W-1:0] dmem_addr,
  output logic [63:0]            dmem_wdata,
  output logic [7:0]             dmem_wstrb,
  input  logic                   dmem_gnt,
  input  logic                   dmem_rvalid,
  input  logic [63:0]            dmem_rdata,
  output logic                   StallM,
  output logic                   ValidW,
  output logic                   RegWriteW,
  output logic [4:0]             RD_W,
  output logic [63:0]            WriteDataW,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                   MisalignW,
`endif
  output logic [1:0]             dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      state_q;
  logic        valid_w_q;
  logic        regwrite_w_q;
  logic [4:0]  rd_w_q;
  logic [63:0] wdata_w_q;

  logic        mem_op;
  logic        is_load;
  logic        trap;
  logic        go;
  logic        in_idle;
  logic        in_wait;
  logic        req;
  logic        store_done;
  logic        load_done;
  logic [2:0]  lane;
  logic [7:0]  strb_raw;
  logic [63:0] wdata_raw;
  logic [63:0] rdata_sh;
  logic [63:0] load_val;
  logic [DMEM_ADDR_W-1:0] addr_full;

  assign lane    = ALU_ResultM[2:0];
  assign mem_op  = ValidM & (MemReadM | MemWriteM);
  // A load takes precedence if both read and write are flagged.
  assign is_load = MemReadM;
  assign in_idle = (state_q == S_IDLE);
  assign in_wait = (state_q == S_WAIT);

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  logic misalign_q;

  // Misaligned means the lane offset is not a multiple of the access size.
  always_comb begin
    misaligned = 1'b0;
    case (MemTypeM)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = |lane[1:0];
      default: misaligned = |lane;
    endcase
  end

  // Only a fresh instruction in IDLE can trap. Once an access has started,
  // it is committed.
  assign trap      = in_idle & mem_op & misaligned;
  assign MisalignW = misalign_q;
`else
  assign trap = 1'b0;
`endif

  assign go  = mem_op & ~trap;
  // The request is raised combinationally in the IDLE cycle, so a same-cycle
  // grant costs no extra cycle.
  assign req = reset_n & ((in_idle & go) | (state_q == S_REQ));

  assign store_done = req & ~is_load & dmem_gnt;
  assign load_done  = reset_n & in_wait & dmem_rvalid;

  // Stall drops in the completion cycle, so that EXE/MEM advances on the same
  // edge that MEM/WB captures the result.
  assign StallM = reset_n & ((req & ~store_done) | (in_wait & ~load_done));

  assign addr_full = ALU_ResultM[DMEM_ADDR_W-1:0];

  // Byte-lane strobes. The 8-bit shift drops lanes beyond 7 on a misaligned access.
  always_comb begin
    strb_raw = 8'h00;
    case (MemTypeM)
      2'b00:   strb_raw = 8'h01 << lane;
      2'b01:   strb_raw = 8'h03 << lane;
      2'b10:   strb_raw = 8'h0F << lane;
      default: strb_raw = 8'hFF;
    endcase
  end

  assign wdata_raw = WriteDataM << {lane, 3'b000};

  // The request fields read zero whenever no request is being made.
  assign dmem_req   = req;
  assign dmem_we    = req & MemWriteM & ~is_load;
  assign dmem_addr  = req ? {addr_full[DMEM_ADDR_W-1:3], 3'b000} : '0;
  assign dmem_wdata = req ? wdata_raw : 64'd0;
  assign dmem_wstrb = req ? strb_raw : 8'h00;

  // Align the addressed bytes to bit 0, then truncate and extend to 64 bits.
  always_comb begin
    rdata_sh = dmem_rdata >> {lane, 3'b000};
    load_val = rdata_sh;
    case (MemTypeM)
      2'b00: load_val = LoadUnsignedM ? {56'd0, rdata_sh[7:0]}
                                      : {{56{rdata_sh[7]}}, rdata_sh[7:0]};
      2'b01: load_val = LoadUnsignedM ? {48'd0, rdata_sh[15:0]}
                                      : {{48{rdata_sh[15]}}, rdata_sh[15:0]};
      2'b10: load_val = LoadUnsignedM ? {32'd0, rdata_sh[31:0]}
                                      : {{32{rdata_sh[31]}}, rdata_sh[31:0]};
      default: load_val = rdata_sh;
    endcase
  end

  // Access FSM and MEM/WB register. Reset abandons any in-flight access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      valid_w_q    <= 1'b0;
      regwrite_w_q <= 1'b0;
      rd_w_q       <= 5'd0;
      wdata_w_q    <= 64'd0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            if (dmem_gnt) state_q <= is_load ? S_WAIT : S_IDLE;
            else          state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (dmem_gnt) state_q <= is_load ? S_WAIT : S_IDLE;
        end
        S_WAIT: begin
          if (dmem_rvalid) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q <= trap;
`endif
      if (trap) begin
        valid_w_q    <= 1'b1;
        regwrite_w_q <= 1'b0;
        rd_w_q       <= RD_M;
        wdata_w_q    <= ALU_ResultM;
      end else if (store_done | load_done) begin
        valid_w_q    <= 1'b1;
        regwrite_w_q <= RegWriteM;
        rd_w_q       <= RD_M;
        wdata_w_q    <= MemToRegM ? load_val : ALU_ResultM;
      end else if (in_idle & ~mem_op) begin
        valid_w_q    <= ValidM;
        regwrite_w_q <= RegWriteM & ValidM;
        rd_w_q       <= RD_M;
        wdata_w_q    <= ALU_ResultM;
      end else begin
        valid_w_q    <= 1'b0;
        regwrite_w_q <= 1'b0;
      end
    end
  end

  assign ValidW      = valid_w_q;
  assign RegWriteW   = regwrite_w_q;
  assign RD_W        = rd_w_q;
  assign WriteDataW  = wdata_w_q;
  assign dbg_state_o = state_q;

endmodule
